// File: rtl/fsqrt_result_collector.sv
// Pairs each operand issued to the fixed-latency fsqrt pipeline with its result and buffers the pairs in a FWFT FIFO.
// Define FSQRT_COLLECT_CHECK_EN to add the zero/denormal result checker and its err_count output.
module fsqrt_result_collector #(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_op,
    input  logic [31:0] fpu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        overflow,
    output logic [31:0] pair_count
`ifdef FSQRT_COLLECT_CHECK_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    // Operand delay line, mirroring the fsqrt pipeline depth; it never stalls.
    logic [LATENCY-1:0] stage_valid_reg;
    logic [31:0]        stage_op_reg [LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid_reg <= '0;
        end else begin
            stage_valid_reg[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                stage_valid_reg[i] <= stage_valid_reg[i-1];
            end
        end
        stage_op_reg[0] <= in_op;
        for (int i = 1; i < LATENCY; i++) begin
            stage_op_reg[i] <= stage_op_reg[i-1];
        end
    end

    logic        cap_valid;
    logic [31:0] cap_op;
    logic [63:0] cap_pair;

    assign cap_valid = stage_valid_reg[LATENCY-1];
    assign cap_op    = stage_op_reg[LATENCY-1];
    assign cap_pair  = {cap_op, fpu_result};

    // Pair FIFO: extra pointer MSB distinguishes full from empty.
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [63:0] mem [DEPTH];
    logic        full;
    logic        empty;
    logic        pop;
    logic        push;
    logic        drop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop   = !empty && out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push  = cap_valid && (!full || pop);
    assign drop  = cap_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr_reg[AW-1:0]] <= cap_pair;
        end
    end

    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr_reg[AW-1:0]];

    logic        overflow_reg;
    logic [31:0] pair_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            overflow_reg   <= 1'b0;
            pair_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg     <= wr_ptr_reg + PTR_ONE;
                pair_count_reg <= pair_count_reg + 32'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign overflow   = overflow_reg;
    assign pair_count = pair_count_reg;

`ifdef FSQRT_COLLECT_CHECK_EN
    // A zero or denormal operand must produce a zero of the same sign.
    logic        special_op;
    logic        check_bad;
    logic [15:0] err_count_reg;

    assign special_op = (cap_op[30:23] == 8'd0);
    assign check_bad  = special_op && (fpu_result != {cap_op[31], 31'b0});

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_reg <= '0;
        end else if (cap_valid && check_bad && (err_count_reg != 16'hFFFF)) begin
            err_count_reg <= err_count_reg + 16'd1;
        end
    end

    assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_fsqrt_result_collector.sv
// Directed bench for fsqrt_result_collector: issue-log/queue reference model checked every cycle plus literal checks.
module tb_fsqrt_result_collector;

    localparam int LAT = 3;
    localparam int DEP = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_op;
    logic [31:0] fpu_result;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        overflow;
    logic [31:0] pair_count;
`ifdef FSQRT_COLLECT_CHECK_EN
    logic [15:0] err_count;
`endif

    always #5 clk = ~clk;

    fsqrt_result_collector #(
        .LATENCY(LAT),
        .DEPTH  (DEP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .fpu_result(fpu_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow),
        .pair_count(pair_count)
`ifdef FSQRT_COLLECT_CHECK_EN
        ,
        .err_count (err_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Stand-in for the fsqrt unit: maps an operand to the value the bench drives on the result bus.
    function automatic logic [31:0] resf(input logic [31:0] op);
        case (op)
            32'h40800000: resf = 32'h40000000;
            32'h00000000: resf = 32'h00000000;
            32'h80000000: resf = 32'h3F800000;
            default:      resf = op ^ 32'h13579BDF;
        endcase
    endfunction

    // Reference model: operands wait in an issue log and are captured exactly LAT edges after issue.
    typedef struct {
        int          t;
        logic [31:0] op;
    } iss_t;

    iss_t        pend[$];
    logic [63:0] mq[$];
    bit          m_ovf;
    logic [31:0] m_cnt;
    logic [15:0] m_err;
    bit          model_ready = 1'b0;
    int          edge_cnt = 0;

    always @(posedge clk) begin : model
        bit          cap;
        bit          pop;
        logic [31:0] c_op;
        edge_cnt++;
        cap  = 1'b0;
        c_op = '0;
        if (reset === 1'b1) begin
            pend.delete();
            mq.delete();
            m_ovf       = 1'b0;
            m_cnt       = '0;
            m_err       = '0;
            model_ready = 1'b1;
        end else begin
            pop = (mq.size() != 0) && (out_ready === 1'b1);
            if (pend.size() != 0 && pend[0].t == edge_cnt - LAT) begin
                cap  = 1'b1;
                c_op = pend[0].op;
                void'(pend.pop_front());
            end
            if (cap && c_op[30:23] == 8'd0 && fpu_result != {c_op[31], 31'b0} && m_err != 16'hFFFF)
                m_err = m_err + 16'd1;
            if (pop) void'(mq.pop_front());
            if (cap) begin
                if (mq.size() < DEP) begin
                    mq.push_back({c_op, fpu_result});
                    m_cnt = m_cnt + 32'd1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (in_valid === 1'b1) pend.push_back(iss_t'{t: edge_cnt, op: in_op});
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            check("out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
            if (mq.size() != 0) check("out_data", out_data, mq[0]);
            check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
            check("pair_count", {32'd0, pair_count}, {32'd0, m_cnt});
`ifdef FSQRT_COLLECT_CHECK_EN
            check("err_count", {48'd0, err_count}, {48'd0, m_err});
`endif
        end
    end

    // Stimulus bookkeeping so the result bus carries resf(op) exactly LAT edges after issue.
    bit          iss_v [4096];
    logic [31:0] iss_o [4096];

    task automatic tick(input logic v, input logic [31:0] op, input logic rdy, input logic rst);
        int e;
        e = edge_cnt + 1;
        iss_v[e % 4096] = v;
        iss_o[e % 4096] = op;
        in_valid  = v;
        in_op     = op;
        out_ready = rdy;
        reset     = rst;
        if (e > LAT && iss_v[(e - LAT) % 4096])
            fpu_result = resf(iss_o[(e - LAT) % 4096]);
        else
            fpu_result = {16'hBAD0, e[15:0]};
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          popped;
        logic [63:0] first;
        logic [63:0] last;
        logic [31:0] v;

        for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b0, 1'b1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_overflow", {63'd0, overflow}, 64'd0);
        check("reset_pair_count", {32'd0, pair_count}, 64'd0);
`ifdef FSQRT_COLLECT_CHECK_EN
        check("reset_err_count", {48'd0, err_count}, 64'd0);
`endif

        // Latency pairing
        tick(1'b1, 32'h40800000, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        check("lat_not_early", {63'd0, out_valid}, 64'd0);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        check("lat_out_valid", {63'd0, out_valid}, 64'd1);
        check("lat_out_data", out_data, 64'h40800000_40000000);
        check("lat_pair_count", {32'd0, pair_count}, 64'd1);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        check("lat_drained", {63'd0, out_valid}, 64'd0);

        // Streaming
        tick(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            v = 32'(i);
            tick(1'b1, v * 32'h9E3779B9, 1'b1, 1'b0);
        end
        for (int i = 0; i < LAT + 2; i++) tick(1'b0, 32'h0, 1'b1, 1'b0);
        check("stream_pair_count", {32'd0, pair_count}, 64'd1000);
        check("stream_overflow", {63'd0, overflow}, 64'd0);
        check("stream_empty", {63'd0, out_valid}, 64'd0);

        // Overflow
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) tick(1'b1, 32'h41000000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < LAT; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
        check("ovf_pair_count", {32'd0, pair_count}, 64'd16);
        check("ovf_flag", {63'd0, overflow}, 64'd1);
        check("ovf_head", out_data, 64'h41000000_52579BDF);

        // Full FIFO with simultaneous push and pop
        tick(1'b1, 32'h77777777, 1'b0, 1'b0);
        for (int i = 0; i < LAT - 1; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        check("fullpop_pair_count", {32'd0, pair_count}, 64'd17);
        check("fullpop_overflow", {63'd0, overflow}, 64'd1);
        check("fullpop_head", out_data, 64'h41000001_52579BDE);
        popped = 0;
        first  = '0;
        last   = '0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid === 1'b1) begin
                if (popped == 0) first = out_data;
                last = out_data;
                popped++;
            end
            tick(1'b0, 32'h0, 1'b1, 1'b0);
        end
        check("fullpop_occupancy", 64'(popped), 64'd16);
        check("fullpop_first", first, 64'h41000001_52579BDE);
        check("fullpop_tail", last, 64'h77777777_6420ECA8);

        // Reset mid-flight
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        tick(1'b1, 32'h3F800000, 1'b1, 1'b0);
        tick(1'b1, 32'h40400000, 1'b1, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < LAT + 3; i++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b0);
            check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
            check("midrst_pair_count", {32'd0, pair_count}, 64'd0);
        end

        // Zero/denormal special case
        tick(1'b0, 32'h0, 1'b1, 1'b1);
        tick(1'b1, 32'h00000000, 1'b0, 1'b0);
        tick(1'b1, 32'h80000000, 1'b0, 1'b0);
        for (int i = 0; i < LAT; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
        check("zero_pair_count", {32'd0, pair_count}, 64'd2);
        check("zero_head", out_data, 64'h00000000_00000000);
`ifdef FSQRT_COLLECT_CHECK_EN
        check("zero_err_count", {48'd0, err_count}, 64'd1);
`endif
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        check("zero_second", out_data, 64'h80000000_3F800000);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fsqrt_result_collector.md
# fsqrt_result_collector

Capture-side companion to the `fsqrt` operand stimulus. It tracks every operand issued to the fixed-latency `fsqrt` pipeline and pairs it with the result that emerges `LATENCY` cycles later. Each `{op, result}` pair is buffered in a first-word-fall-through FIFO and drained through a ready/valid port for logging or host readout. It sits beside `fsqrt` in the FPU sample/verification harness and observes the unit's operand and result buses without driving them.

## Interface
- `LATENCY`, 3: `fsqrt` pipeline depth in clocks; legal range 1–8.
- `DEPTH`, 16: pair FIFO entries; must be a power of two, minimum 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `in_valid`  in  1  an operand is presented to `fsqrt` this cycle.
- `in_op`  in  32  operand presented to `fsqrt` (IEEE-754 single).
- `fpu_result`  in  32  `fsqrt` result bus.
- `out_valid`  out  1  FIFO head holds a pair.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `out_data`  out  64  `{op[31:0], result[31:0]}` at the FIFO head.
- `overflow`  out  1  sticky; at least one pair was dropped.
- `pair_count`  out  32  pairs accepted into the FIFO since reset; wraps modulo 2^32.
- `err_count`  out  16  special-case check failures; present only with `FSQRT_COLLECT_CHECK_EN`.

## Operation
- **Delay line.** `LATENCY` stages, each holding `{valid, op}`. Stage 0 loads `{in_valid, in_op}` every cycle. There is no stall: the delay line always advances.
- **Pairing.** When the last stage is valid, the capture point pairs it with the `fpu_result` sampled on that same edge, forming `{op, fpu_result}`.
- **FIFO.** Read and write pointers are `log2(DEPTH)+1` bits wide, with the MSB used for wrap detection.
  - full = pointers differ only in the MSB.
  - empty = pointers are equal.
- **Push.** A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the pair is dropped and `overflow` is set to 1. `overflow` stays set until reset.
  - `pair_count` increments only on accepted pushes.
- **Pop.** A pop occurs when `out_valid && out_ready`.
  - `out_valid` = !empty.
  - `out_data` is the head entry, driven combinationally from storage.
  - `out_ready` while empty has no effect.
- **Simultaneous push and pop.**
  - On an empty FIFO: the new pair becomes visible on the next cycle. There is no combinational bypass.
  - On a full FIFO: occupancy stays at `DEPTH`.
- **Reset.**
  - All delay-line valid bits, both pointers, `overflow`, `pair_count` and `err_count` are cleared.
  - Operands in flight at reset are discarded, so results for them never enter the FIFO.
  - FIFO data storage is not cleared.

## Timing
- Reset values: `out_valid`=0, `overflow`=0, `pair_count`=0, `err_count`=0. `out_data` is undefined while `out_valid`=0.
- Operand sampled at edge t:
  - pushed at edge t+`LATENCY`;
  - `out_valid` high from cycle t+`LATENCY`+1 if the FIFO was empty;
  - `pair_count` increments at edge t+`LATENCY`.
- Throughput is one pair per cycle in each direction. Back-to-back `in_valid` is legal every cycle.
- `reset` asserted in cycle t takes priority over any push or pop in cycle t.

## Configuration
- `FSQRT_COLLECT_CHECK_EN` defined:
  - At each accepted or dropped capture, the block checks the zero/denormal special case. If `op[30:23]==0`, the result must equal `{op[31], 31'b0}` (signed zero).
  - On a mismatch, `err_count` increments, saturating at 16'hFFFF.
  - The check uses the captured pair, so it is independent of the push outcome.
- Not defined: the `err_count` port and its checker logic are absent, and all other behaviour is identical.

## Test plan
- **Latency pairing.** Reset, then `in_op`=32'h40800000 for one cycle, with `fpu_result` driven to 32'h40000000 exactly 3 cycles later. Required: `out_valid`=1 on cycle 4, `out_data`=64'h40800000_40000000, `pair_count`=1.
- **Streaming.** 1000 back-to-back random operands with `out_ready`=1 every cycle. Required: pairs come out in issue order, `overflow`=0, and `pair_count`=1000.
- **Overflow.** `out_ready`=0, 20 operands issued with `DEPTH`=16. Required: exactly 16 pairs retained (the first 16), `overflow`=1, `pair_count`=16.
- **Full with simultaneous pop.** FIFO full, then one push and one pop in the same cycle. Required: occupancy stays 16, `overflow` unchanged, and the new pair sits at the tail.
- **Reset mid-flight.** Issue 2 operands, assert `reset` one cycle later. Required: no pairs appear, `out_valid`=0, `pair_count`=0.
- **Zero check** (with `FSQRT_COLLECT_CHECK_EN`). Operands 32'h00000000 → result 32'h00000000, and 32'h80000000 → result 32'h3F800000. Required: `err_count`=1.
